// File: rtl/fetch_queue.sv
// fetch_queue
//   Instruction fetch queue between the IF and ID stages. Each entry holds a
//   {pc, instr} pair (pc is the PC+4 value from IF). A ready/valid handshake
//   decouples IF from ID stalls, and a taken branch (flush) empties the queue
//   in one cycle. IF freeze is driven from ~in_ready.
//
// Parameters
//   DEPTH     number of entries, power of two, minimum 2
//   WIDTH     width of the pc field and of the instruction field
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   flush      Branch_Taken from EXE; discards all queued entries
//   in_valid   IF presents a fetched pair this cycle
//   in_pc      PC+4 of the fetched instruction
//   in_instr   fetched instruction word
//   in_ready   queue can accept an entry
//   out_valid  head entry is valid for ID
//   out_pc     pc field of the head entry (0 when out_valid = 0)
//   out_instr  instr field of the head entry (0 when out_valid = 0)
//   out_ready  ID consumes the head entry
//   count      number of valid entries

module fetch_queue #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 32
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       flush,
   input  logic                       in_valid,
   input  logic [WIDTH-1:0]           in_pc,
   input  logic [WIDTH-1:0]           in_instr,
   output logic                       in_ready,
   output logic                       out_valid,
   output logic [WIDTH-1:0]           out_pc,
   output logic [WIDTH-1:0]           out_instr,
   input  logic                       out_ready,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0]   count_q,  count_d;

   // Storage is never cleared; outputs are masked while the queue is empty.
   logic [2*WIDTH-1:0] mem_q [DEPTH];
   logic [2*WIDTH-1:0] mem_d [DEPTH];

   logic push;
   logic pop;

   // Handshake flags depend only on the registered count.
   assign in_ready  = (count_q != CNT_W'(DEPTH));
   assign out_valid = (count_q != '0);
   assign count     = count_q;

   assign push = in_valid  & in_ready  & ~flush;
   assign pop  = out_valid & out_ready & ~flush;

   // Head entry, forced to a NOP bubble (all zero) when empty.
   always_comb begin
      out_pc    = '0;
      out_instr = '0;
      if (out_valid) begin
         out_pc    = mem_q[rd_ptr_q][2*WIDTH-1:WIDTH];
         out_instr = mem_q[rd_ptr_q][WIDTH-1:0];
      end
   end

   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         mem_d[i] = mem_q[i];
      end

      if (flush) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) begin
            mem_d[wr_ptr_q] = {in_pc, in_instr};
            // Power-of-two depth: binary rollover is the wrap.
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end
         if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
         end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
         mem_q[i] <= mem_d[i];
      end
   end

endmodule
